// File: rtl/edge_pkg.sv
// edge_pkg: shared definitions for the edge_pulse_gen block.
//   - per-channel edge-select encodings
//   - pulse counter state type
//   - counter width helper
package edge_pkg;

    // Edge-select encodings, one 2-bit field per channel.
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Pulse stretcher state: IDLE <=> cnt == 0, ACTIVE <=> cnt > 0.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } pulse_state_e;

    // Width needed to hold the values 0..len.
    function automatic int cnt_width(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/edge_pulse_chan.sv
// edge_pulse_chan: one channel of the edge pulse generator.
//   Synchronises a raw asynchronous input, detects the selected edge(s),
//   stretches each detected edge into a PULSE_LEN-cycle registered pulse
//   (retriggerable) and keeps a sticky pending flag.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   in      in   raw asynchronous input
//   mode    in   [1:0] edge select (off / rise / fall / both)
//   clr     in   pending clear strobe
//   out     out  stretched pulse, registered
//   pending out  sticky edge-seen flag
module edge_pulse_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       out,
    output logic       pending
);

    localparam int CW = cnt_width(PULSE_LEN);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   hit;

    pulse_state_e           state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   out_n;

    // Synchroniser chain plus one extra sample for edge detection. Reset to 0,
    // so an input held high through reset shows up as a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in};
            prev <= s;
        end
    end

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~prev;
    assign fall = ~s & prev;

    // Mode is used combinationally so a mode change acts in the same cycle.
    always_comb begin
        hit = 1'b0;
        case (mode)
            MODE_RISE: hit = rise;
            MODE_FALL: hit = fall;
            MODE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            out   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            out   <= out_n;
        end
    end

    // A hit always reloads, so a retrigger while ACTIVE extends the pulse
    // without a gap. Mode only gates hit, never an ongoing pulse.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = out;
        if (hit) begin
            cnt_n   = CW'(PULSE_LEN);
            out_n   = 1'b1;
            state_n = ST_ACTIVE;
        end else begin
            case (state)
                ST_ACTIVE: begin
                    cnt_n   = cnt - CW'(1);
                    out_n   = (cnt_n != '0);
                    state_n = out_n ? ST_ACTIVE : ST_IDLE;
                end
                default: begin
                    cnt_n   = '0;
                    out_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Set has priority over clear in a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= 1'b0;
        else     pending <= hit | (pending & ~clr);
    end

endmodule

// File: rtl/edge_pulse_gen.sv
// edge_pulse_gen: multi-channel edge detector with pulse stretching.
//   CHANNELS independent edge_pulse_chan instances plus an aggregate irq.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   in      in   [CHANNELS]    raw asynchronous inputs
//   mode    in   [2*CHANNELS]  edge select, bits [2i+1:2i] for channel i
//   irq_en  in   [CHANNELS]    interrupt enables
//   clr     in   [CHANNELS]    pending clear strobes
//   out     out  [CHANNELS]    stretched edge pulses, registered
//   pending out  [CHANNELS]    sticky edge-seen flags
//   irq     out  OR of (pending & irq_en)
module edge_pulse_gen
    import edge_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   irq_en,
    input  logic [CHANNELS-1:0]   clr,
    output logic [CHANNELS-1:0]   out,
    output logic [CHANNELS-1:0]   pending,
    output logic                  irq
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        edge_pulse_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .PULSE_LEN   (PULSE_LEN)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .in      (in[i]),
            .mode    (mode[2*i +: 2]),
            .clr     (clr[i]),
            .out     (out[i]),
            .pending (pending[i])
        );
    end

    // Combinational from registers only.
    assign irq = |(pending & irq_en);

endmodule

// File: tb/tb_edge_pulse_gen.sv
// tb_edge_pulse_gen: directed + randomized bench for edge_pulse_gen.
// The reference model keeps a history of sampled inputs (s is the sample
// SYNC_STAGES-1 edges old, p one edge older) and the edge index of each
// channel's most recent hit; out is high while fewer than PULSE_LEN edges
// have passed since that hit.
module tb_edge_pulse_gen;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int PL = 2;

    logic            clk;
    logic            rst;
    logic [CH-1:0]   din;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   irq_en;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   dout;
    logic [CH-1:0]   pend;
    logic            irq;

    int checks = 0;
    int errors = 0;

    edge_pulse_gen #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SS),
        .PULSE_LEN   (PL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (din),
        .mode    (mode),
        .irq_en  (irq_en),
        .clr     (clr),
        .out     (dout),
        .pending (pend),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [CH-1:0] hq[$];
    int            e;
    int            last_hit[CH];
    logic [CH-1:0] pend_m;

    function automatic void model_reset();
        hq.delete();
        for (int k = 0; k <= SS; k++) hq.push_back('0);
        e = 0;
        for (int i = 0; i < CH; i++) last_hit[i] = -1000;
        pend_m = '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: evaluate model hits from pre-edge inputs, advance, then
    // compare all outputs 1 time unit after the edge.
    task automatic tick();
        logic [CH-1:0] s, p, hit, exp_out;
        s = hq[1];
        p = hq[0];
        for (int i = 0; i < CH; i++) begin
            case (mode[2*i +: 2])
                2'b01:   hit[i] = s[i] & ~p[i];
                2'b10:   hit[i] = ~s[i] & p[i];
                2'b11:   hit[i] = s[i] ^ p[i];
                default: hit[i] = 1'b0;
            endcase
        end
        @(posedge clk);
        if (!rst) begin
            e++;
            for (int i = 0; i < CH; i++) if (hit[i]) last_hit[i] = e;
            pend_m = hit | (pend_m & ~clr);
            hq.push_back(din);
            void'(hq.pop_front());
        end
        #1;
        for (int i = 0; i < CH; i++) exp_out[i] = !rst && ((e - last_hit[i]) < PL);
        chk("out", 32'(dout), 32'(exp_out));
        chk("pending", 32'(pend), 32'(rst ? '0 : pend_m));
        chk("irq", 32'(irq), 32'(!rst && |(pend_m & irq_en)));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int highs, first, last;
        bit seen;

        rst    = 1'b1;
        din    = 4'b0001;
        mode   = 8'b01_11_10_01;   // ch3 rise, ch2 both, ch1 fall, ch0 rise
        irq_en = '0;
        clr    = '0;
        model_reset();

        // Reset state, then ch0 held high through release shows a rise.
        repeat (2) tick();
        rst = 1'b0;
        highs = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (dout[0]) highs++;
        end
        chk("rst_rise_len", 32'(highs), 32'(PL));
        chk("rst_rise_pend", 32'(pend), 32'(4'b0001));

        // Falling mode on ch1: rise ignored, fall detected, irq, clear.
        din[1] = 1'b1;
        repeat (5) tick();
        chk("fall_no_rise", 32'(pend[1]), 32'd0);
        irq_en = 4'b0010;
        din[1] = 1'b0;
        highs = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (dout[1]) highs++;
        end
        chk("fall_len", 32'(highs), 32'(PL));
        chk("fall_pend", 32'(pend[1]), 32'd1);
        chk("fall_irq", 32'(irq), 32'd1);
        clr = 4'b0010;
        tick();
        clr = '0;
        chk("clr_pend", 32'(pend[1]), 32'd0);
        chk("clr_irq", 32'(irq), 32'd0);

        // Set/clear collision on ch3 (rise mode).
        din[3] = 1'b1;
        tick();
        tick();              // hit is now high for the coming edge
        clr = 4'b1000;
        tick();
        clr = '0;
        chk("collide_set_wins", 32'(pend[3]), 32'd1);
        clr = 4'b1000;
        tick();
        clr = '0;
        chk("collide_then_clr", 32'(pend[3]), 32'd0);

        // Both-edge retrigger on ch2: rise then fall two cycles later.
        repeat (4) tick();
        din[2] = 1'b1;
        tick();
        tick();
        din[2] = 1'b0;
        highs = 0; first = -1; last = -1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (dout[2]) begin
                highs++;
                if (first < 0) first = k;
                last = k;
            end
        end
        chk("retrig_len", 32'(highs), 32'(2 + PL));
        chk("retrig_nogap", 32'(last - first + 1), 32'(2 + PL));

        // mode=00 on ch0: toggles ignored; enabling rise on a steady high is quiet.
        clr = 4'b0001;
        tick();
        clr = '0;
        mode[1:0] = 2'b00;
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            if (k % 5 == 0) din[0] = ~din[0];
            tick();
            if (dout[0]) highs++;
        end
        chk("off_out", 32'(highs), 32'd0);
        chk("off_pend", 32'(pend[0]), 32'd0);
        chk("off_in_high", 32'(din[0]), 32'd1);
        repeat (4) tick();
        mode[1:0] = 2'b01;
        highs = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (dout[0]) highs++;
        end
        chk("mode_switch_quiet", 32'(highs) + 32'(pend[0]), 32'd0);
        din[0] = 1'b0;
        repeat (3) tick();
        din[0] = 1'b1;
        highs = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (dout[0]) highs++;
        end
        chk("mode_switch_rise", 32'(highs), 32'(PL));

        // Async reset mid-pulse, away from the clock edge.
        irq_en = '1;
        din[0] = 1'b0;
        repeat (3) tick();
        din[0] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            seen = dout[0];
        end
        chk("rst_wait_pulse", 32'(seen), 32'd1);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_out", 32'(dout), 32'd0);
        chk("async_rst_pend", 32'(pend), 32'd0);
        chk("async_rst_irq", 32'(irq), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        highs = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (dout[0]) highs++;
        end
        chk("post_rst_len", 32'(highs), 32'(PL));

        // Randomized phase against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) != 0) din = CH'($urandom);
            if ($urandom_range(0, 15) == 0) mode = (2*CH)'($urandom);
            if ($urandom_range(0, 7) == 0) irq_en = CH'($urandom);
            clr = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
            tick();
        end
        clr = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
